chronologic: RTL and testbench

CHRONOLOGIC -- requirements
Module: chronologic

---
 rtl/chronologic.sv | 80 ++++++++
 tb/tb_chronologic.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chronologic.sv
// Sample register that accepts only fully-known input words, tracks an accepted-sample
// count, and flags (one-shot and sticky) any qualified word carrying X/Z bits.
module chronologic #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input_signal,
    input  logic             in_valid,
    output logic             output_signal,
    output logic [WIDTH-1:0] data_q,
    output logic             parity_q,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             x_flag,
    output logic             x_seen
);

    logic             valid_s;
    logic             unknown_s;
    logic             accept_s;
    logic             reject_s;

    logic [WIDTH-1:0] sample_q, sample_d;
    logic             bit0_q, bit0_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xflag_q, xflag_d;
    logic             xseen_q, xseen_d;

    // An unknown in_valid never matches 1, so it behaves as a plain hold.
    // $isunknown is constant 0 in synthesis, so hardware always sees a clean input.
    always_comb begin
        valid_s   = (in_valid === 1'b1);
        unknown_s = $isunknown(input_signal);
        accept_s  = valid_s && !unknown_s;
        reject_s  = valid_s && unknown_s;
    end

    always_comb begin
        sample_d = sample_q;
        bit0_d   = bit0_q;
        par_d    = par_q;
        cnt_d    = cnt_q;
        xflag_d  = reject_s;
        xseen_d  = xseen_q | reject_s;
        if (accept_s) begin
            sample_d = input_signal;
            bit0_d   = input_signal[0];
            par_d    = ^input_signal;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            bit0_q   <= 1'b0;
            par_q    <= 1'b0;
            cnt_q    <= '0;
            xflag_q  <= 1'b0;
            xseen_q  <= 1'b0;
        end else begin
            sample_q <= sample_d;
            bit0_q   <= bit0_d;
            par_q    <= par_d;
            cnt_q    <= cnt_d;
            xflag_q  <= xflag_d;
            xseen_q  <= xseen_d;
        end
    end

    assign output_signal = bit0_q;
    assign data_q        = sample_q;
    assign parity_q      = par_q;
    assign sample_cnt    = cnt_q;
    assign x_flag        = xflag_q;
    assign x_seen        = xseen_q;

endmodule

// File: tb/tb_chronologic.sv
// Directed bench for chronologic: reset, streaming accepts, unknown rejection,
// hold, unknown in_valid, asynchronous reset and counter wrap.
module tb_chronologic;

    logic        clk;
    logic        rst_n;
    logic [7:0]  input_signal;
    logic        in_valid;
    logic        output_signal;
    logic [7:0]  data_q;
    logic        parity_q;
    logic [15:0] sample_cnt;
    logic        x_flag;
    logic        x_seen;

    int          checks;
    int          fails;
    logic [15:0] exp_cnt;
    logic        rst_applied;
    logic        exp_xseen;

    chronologic #(.WIDTH(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_signal (input_signal),
        .in_valid     (in_valid),
        .output_signal(output_signal),
        .data_q       (data_q),
        .parity_q     (parity_q),
        .sample_cnt   (sample_cnt),
        .x_flag       (x_flag),
        .x_seen       (x_seen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data outputs must never carry unknowns once reset has been applied.
    always @(negedge clk) begin
        if (rst_applied) begin
            checks++;
            if ($isunknown({output_signal, data_q, parity_q})) begin
                fails++;
                $display("FAIL no_unknown_out: got out=%b data=%h par=%b expected known values",
                         output_signal, data_q, parity_q);
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk);
        in_valid     = v;
        input_signal = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; in_valid = 1'b0; input_signal = 8'h00;
        #2 rst_n = 1'b0;
        rst_applied = 1'b1;
        #1;
        checks++;
        if ({output_signal, data_q, parity_q, sample_cnt, x_flag, x_seen} !== 28'h0) begin
            fails++;
            $display("FAIL reset_immediate: got out=%b data=%h par=%b cnt=%h xf=%b xs=%b expected all 0",
                     output_signal, data_q, parity_q, sample_cnt, x_flag, x_seen);
        end
        #7 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({output_signal, data_q, parity_q, sample_cnt, x_flag, x_seen} !== 28'h0) begin
            fails++;
            $display("FAIL reset_release_edge: got out=%b data=%h par=%b cnt=%h xf=%b xs=%b expected all 0",
                     output_signal, data_q, parity_q, sample_cnt, x_flag, x_seen);
        end
        exp_cnt   = 16'd0;
        exp_xseen = 1'b0;
    endtask

    task automatic test_stream;
        logic [7:0] vals [4];
        logic       bits [4];
        vals = '{8'hAA, 8'h55, 8'hFF, 8'h00};
        bits = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i]);
            exp_cnt = exp_cnt + 16'd1;
            checks++;
            if (output_signal !== bits[i] || data_q !== vals[i] || parity_q !== 1'b0 ||
                sample_cnt !== exp_cnt || x_flag !== 1'b0) begin
                fails++;
                $display("FAIL stream_%0d: got out=%b data=%h par=%b cnt=%0d xf=%b expected out=%b data=%h par=0 cnt=%0d xf=0",
                         i, output_signal, data_q, parity_q, sample_cnt, x_flag, bits[i], vals[i], exp_cnt);
            end
        end
    endtask

    task automatic test_unknown;
        logic [7:0] xv;
        logic       xs;
        xv = 8'bxxxx_xxxx;
        xs = $isunknown(xv);
        drive(1'b1, 8'h00);
        exp_cnt = exp_cnt + 16'd1;
        drive(1'b1, xv);
        if (xs) begin
            exp_xseen = 1'b1;
            checks++;
            if (output_signal !== 1'b0 || data_q !== 8'h00 || sample_cnt !== exp_cnt ||
                x_flag !== 1'b1 || x_seen !== 1'b1) begin
                fails++;
                $display("FAIL unknown_reject: got out=%b data=%h cnt=%0d xf=%b xs=%b expected out=0 data=00 cnt=%0d xf=1 xs=1",
                         output_signal, data_q, sample_cnt, x_flag, x_seen, exp_cnt);
            end
        end else begin
            // A two-state simulator has already resolved the unknowns; treat as a clean word.
            exp_cnt = exp_cnt + 16'd1;
            checks++;
            if (data_q !== xv || output_signal !== xv[0] || parity_q !== ^xv ||
                sample_cnt !== exp_cnt || x_flag !== 1'b0 || x_seen !== 1'b0) begin
                fails++;
                $display("FAIL unknown_resolved: got data=%h cnt=%0d xf=%b xs=%b expected data=%h cnt=%0d xf=0 xs=0",
                         data_q, sample_cnt, x_flag, x_seen, xv, exp_cnt);
            end
        end
        drive(1'b0, 8'h00);
        checks++;
        if (x_flag !== 1'b0 || x_seen !== exp_xseen || sample_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL unknown_after: got xf=%b xs=%b cnt=%0d expected xf=0 xs=%b cnt=%0d",
                     x_flag, x_seen, sample_cnt, exp_xseen, exp_cnt);
        end
    endtask

    task automatic test_hold;
        drive(1'b1, 8'h01);
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (output_signal !== 1'b1 || data_q !== 8'h01 || parity_q !== 1'b1 || sample_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL hold_load: got out=%b data=%h par=%b cnt=%0d expected out=1 data=01 par=1 cnt=%0d",
                     output_signal, data_q, parity_q, sample_cnt, exp_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'hFE);
            checks++;
            if (output_signal !== 1'b1 || data_q !== 8'h01 || parity_q !== 1'b1 ||
                sample_cnt !== exp_cnt || x_seen !== exp_xseen) begin
                fails++;
                $display("FAIL hold_%0d: got out=%b data=%h par=%b cnt=%0d xs=%b expected out=1 data=01 par=1 cnt=%0d xs=%b",
                         i, output_signal, data_q, parity_q, sample_cnt, x_seen, exp_cnt, exp_xseen);
            end
        end
    endtask

    task automatic test_invalid_x;
        logic iv;
        iv = 1'bx;
        drive(iv, 8'h3C);
        if (iv === 1'b1) begin
            exp_cnt = exp_cnt + 16'd1;
            checks++;
            if (data_q !== 8'h3C || parity_q !== 1'b0 || sample_cnt !== exp_cnt || x_flag !== 1'b0) begin
                fails++;
                $display("FAIL invalid_x_accept: got data=%h cnt=%0d xf=%b expected data=3c cnt=%0d xf=0",
                         data_q, sample_cnt, x_flag, exp_cnt);
            end
        end else begin
            checks++;
            if (data_q !== 8'h01 || output_signal !== 1'b1 || sample_cnt !== exp_cnt || x_flag !== 1'b0) begin
                fails++;
                $display("FAIL invalid_x_hold: got out=%b data=%h cnt=%0d xf=%b expected out=1 data=01 cnt=%0d xf=0",
                         output_signal, data_q, sample_cnt, x_flag, exp_cnt);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] xv;
        xv = 8'bzzzz_xxxx;
        drive(1'b1, 8'hFF);
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (data_q !== 8'hFF || output_signal !== 1'b1 || parity_q !== 1'b0 || sample_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL async_preload: got data=%h out=%b par=%b cnt=%0d expected data=ff out=1 par=0 cnt=%0d",
                     data_q, output_signal, parity_q, sample_cnt, exp_cnt);
        end
        if ($isunknown(xv)) begin
            drive(1'b1, xv);
            checks++;
            if (data_q !== 8'hFF || x_seen !== 1'b1 || x_flag !== 1'b1) begin
                fails++;
                $display("FAIL async_xseen_set: got data=%h xf=%b xs=%b expected data=ff xf=1 xs=1",
                         data_q, x_flag, x_seen);
            end
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({output_signal, data_q, parity_q, sample_cnt, x_flag, x_seen} !== 28'h0) begin
            fails++;
            $display("FAIL async_reset: got out=%b data=%h par=%b cnt=%h xf=%b xs=%b expected all 0",
                     output_signal, data_q, parity_q, sample_cnt, x_flag, x_seen);
        end
        in_valid = 1'b1; input_signal = 8'h3C;
        @(posedge clk); #1;
        checks++;
        if ({output_signal, data_q, parity_q, sample_cnt, x_flag, x_seen} !== 28'h0) begin
            fails++;
            $display("FAIL reset_held_edge: got data=%h cnt=%h expected data=00 cnt=0000", data_q, sample_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_cnt   = 16'd1;
        exp_xseen = 1'b0;
        checks++;
        if (data_q !== 8'h3C || output_signal !== 1'b0 || sample_cnt !== exp_cnt || x_seen !== 1'b0) begin
            fails++;
            $display("FAIL release_accept: got data=%h out=%b cnt=%0d xs=%b expected data=3c out=0 cnt=1 xs=0",
                     data_q, output_signal, sample_cnt, x_seen);
        end
    endtask

    task automatic test_wrap;
        while (exp_cnt != 16'hFFFF) begin
            drive(1'b1, exp_cnt[7:0]);
            exp_cnt = exp_cnt + 16'd1;
        end
        checks++;
        if (sample_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_preload: got cnt=%h expected ffff", sample_cnt);
        end
        drive(1'b1, 8'h81);
        checks++;
        if (sample_cnt !== 16'h0000 || data_q !== 8'h81 || output_signal !== 1'b1 || parity_q !== 1'b0) begin
            fails++;
            $display("FAIL wrap_zero: got cnt=%h data=%h out=%b par=%b expected cnt=0000 data=81 out=1 par=0",
                     sample_cnt, data_q, output_signal, parity_q);
        end
    endtask

    initial begin
        checks      = 0;
        fails       = 0;
        rst_applied = 1'b0;
        test_reset;
        test_stream;
        test_unknown;
        test_hold;
        test_invalid_x;
        test_async_reset;
        test_wrap;
        @(negedge clk);
        rst_applied = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
